// File: rtl/dpram_req_arbiter_pkg.sv
// Shared defaults, FSM encoding and helpers for the dual-port RAM request arbiter.
package dpram_req_arbiter_pkg;

    localparam int DEF_DW          = 8;
    localparam int DEF_AW          = 8;
    localparam int DEF_DEPTH       = 20;
    localparam int DEF_INIT_CYCLES = 2;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [0:0] ST_INIT = INIT;
    localparam logic [0:0] ST_RUN  = RUN;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dpram_req_arbiter_if.sv
// One client port of the arbiter: request channel plus a response channel with no backpressure.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; a stalled client
// keeps req_valid and its payload stable; rsp_valid is a one-cycle pulse the client must take.
interface dpram_req_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dpram_rsp_track.sv
// Per-port response tracker: remembers one accepted request and emits its response the next cycle.
module dpram_rsp_track #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept,
    input  logic          we,
    input  logic          err,
    input  logic [DW-1:0] ram_read,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);
    logic pend;
    logic pend_we;
    logic pend_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            pend_we  <= 1'b0;
            pend_err <= 1'b0;
        end else begin
            pend     <= accept;
            pend_we  <= accept & we;
            pend_err <= accept & err;
        end
    end

    // RAM read data arrives one cycle after the address, exactly in the response cycle.
    assign rsp_valid = pend;
    assign rsp_err   = pend & pend_err;
    assign rsp_rdata = (pend && !pend_we && !pend_err) ? ram_read : '0;

endmodule

// File: rtl/dpram_req_arbiter.sv
// Arbitrates two clients onto a true dual-port RAM; only same-address conflicts involving a write
// are serialised, alternating the winner so neither client starves.
module dpram_req_arbiter
    import dpram_req_arbiter_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int AW          = DEF_AW,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    dpram_req_arbiter_if.slave  a,
    dpram_req_arbiter_if.slave  b,
    output logic                ram_rst,
    output logic                ram_we_a,
    output logic                ram_we_b,
    output logic [AW-1:0]       ram_add_a,
    output logic [AW-1:0]       ram_add_b,
    output logic [DW-1:0]       ram_data_a,
    output logic [DW-1:0]       ram_data_b,
    input  logic [DW-1:0]       ram_read_a,
    input  logic [DW-1:0]       ram_read_b,
    output logic [15:0]         conflict_cnt,
    output logic [0:0]          state_dbg
);
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
    localparam logic [AW:0]    DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [0:0]     state;
    logic [ICW-1:0] init_cnt;
    logic           prio;
    logic           run;
    logic           a_in, b_in;
    logic           conflict;
    logic           a_acc, b_acc;

    assign run       = (state == ST_RUN);
    assign state_dbg = state;
    assign ram_rst   = ~run;

    assign a_in = ({1'b0, a.req_addr} < DEPTH_LIM);
    assign b_in = ({1'b0, b.req_addr} < DEPTH_LIM);

    // Readies are built from valids/addresses/prio only, never from the other port's ready.
    assign conflict = run && a.req_valid && b.req_valid && a_in && b_in &&
                      (a.req_addr == b.req_addr) && (a.req_we || b.req_we);

    assign a.req_ready = run && !(conflict && prio);
    assign b.req_ready = run && !(conflict && !prio);

    assign a_acc = a.req_valid && a.req_ready;
    assign b_acc = b.req_valid && b.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            prio         <= 1'b0;
            conflict_cnt <= 16'd0;
        end else begin
            if (state == ST_INIT) begin
                if (init_cnt == INIT_LAST) state <= ST_RUN;
                else                       init_cnt <= init_cnt + 1'b1;
            end
            if (conflict) begin
                prio         <= ~prio;
                conflict_cnt <= sat_inc16(conflict_cnt);
            end
        end
    end

    // Out-of-range requests are accepted but never reach the RAM.
    always_comb begin
        ram_we_a   = 1'b0;
        ram_add_a  = '0;
        ram_data_a = '0;
        ram_we_b   = 1'b0;
        ram_add_b  = '0;
        ram_data_b = '0;
        if (a_acc && a_in) begin
            ram_we_a   = a.req_we;
            ram_add_a  = a.req_addr;
            ram_data_a = a.req_wdata;
        end
        if (b_acc && b_in) begin
            ram_we_b   = b.req_we;
            ram_add_b  = b.req_addr;
            ram_data_b = b.req_wdata;
        end
    end

    dpram_rsp_track #(.DW(DW)) u_trk_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (a_acc),
        .we        (a.req_we),
        .err       (~a_in),
        .ram_read  (ram_read_a),
        .rsp_valid (a.rsp_valid),
        .rsp_rdata (a.rsp_rdata),
        .rsp_err   (a.rsp_err)
    );

    dpram_rsp_track #(.DW(DW)) u_trk_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (b_acc),
        .we        (b.req_we),
        .err       (~b_in),
        .ram_read  (ram_read_b),
        .rsp_valid (b.rsp_valid),
        .rsp_rdata (b.rsp_rdata),
        .rsp_err   (b.rsp_err)
    );

endmodule

// File: tb/tb_dpram_req_arbiter.sv
// Directed bench for dpram_req_arbiter: reset/INIT sequence, a per-cycle vector table, and a
// mid-transaction reset, against a behavioural read-first dual-port RAM.
module tb_dpram_req_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ram_rst;
    logic        ram_we_a, ram_we_b;
    logic [7:0]  ram_add_a, ram_add_b;
    logic [7:0]  ram_data_a, ram_data_b;
    logic [7:0]  ram_read_a, ram_read_b;
    logic [15:0] conflict_cnt;
    logic [0:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    dpram_req_arbiter_if #(.DW(8), .AW(8)) a_if ();
    dpram_req_arbiter_if #(.DW(8), .AW(8)) b_if ();

    dpram_req_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a_if),
        .b            (b_if),
        .ram_rst      (ram_rst),
        .ram_we_a     (ram_we_a),
        .ram_we_b     (ram_we_b),
        .ram_add_a    (ram_add_a),
        .ram_add_b    (ram_add_b),
        .ram_data_a   (ram_data_a),
        .ram_data_b   (ram_data_b),
        .ram_read_a   (ram_read_a),
        .ram_read_b   (ram_read_b),
        .conflict_cnt (conflict_cnt),
        .state_dbg    (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // read-first dual-port RAM, mem[i] preloaded with i + 0x40
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 'h40);
        ram_read_a = 8'h00;
        ram_read_b = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_add_a] <= ram_data_a;
        if (ram_we_b) mem[ram_add_b] <= ram_data_b;
        ram_read_a <= mem[ram_add_a];
        ram_read_b <= mem[ram_add_b];
    end

    typedef struct {
        logic av; logic awe; logic [7:0] aaddr; logic [7:0] awd;
        logic bv; logic bwe; logic [7:0] baddr; logic [7:0] bwd;
        logic ar; logic br;
        logic wa; logic [7:0] ada; logic [7:0] dta;
        logic wb; logic [7:0] adb; logic [7:0] dtb;
        logic arv; logic [7:0] ard; logic are;
        logic brv; logic [7:0] brd; logic bre;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic awe, input logic [7:0] aaddr, input logic [7:0] awd,
                         input logic bv, input logic bwe, input logic [7:0] baddr, input logic [7:0] bwd);
        a_if.req_valid = av;  a_if.req_we = awe;  a_if.req_addr = aaddr;  a_if.req_wdata = awd;
        b_if.req_valid = bv;  b_if.req_we = bwe;  b_if.req_addr = baddr;  b_if.req_wdata = bwd;
    endtask

    task automatic check_vec(input int i);
        vec_t v;
        v = vecs[i];
        chk($sformatf("v%0d a_ready", i),   32'(a_if.req_ready), 32'(v.ar));
        chk($sformatf("v%0d b_ready", i),   32'(b_if.req_ready), 32'(v.br));
        chk($sformatf("v%0d ram_we_a", i),  32'(ram_we_a),       32'(v.wa));
        chk($sformatf("v%0d ram_add_a", i), 32'(ram_add_a),      32'(v.ada));
        chk($sformatf("v%0d ram_data_a", i),32'(ram_data_a),     32'(v.dta));
        chk($sformatf("v%0d ram_we_b", i),  32'(ram_we_b),       32'(v.wb));
        chk($sformatf("v%0d ram_add_b", i), 32'(ram_add_b),      32'(v.adb));
        chk($sformatf("v%0d ram_data_b", i),32'(ram_data_b),     32'(v.dtb));
        chk($sformatf("v%0d a_rsp_valid", i), 32'(a_if.rsp_valid), 32'(v.arv));
        chk($sformatf("v%0d a_rsp_rdata", i), 32'(a_if.rsp_rdata), 32'(v.ard));
        chk($sformatf("v%0d a_rsp_err", i),   32'(a_if.rsp_err),   32'(v.are));
        chk($sformatf("v%0d b_rsp_valid", i), 32'(b_if.rsp_valid), 32'(v.brv));
        chk($sformatf("v%0d b_rsp_rdata", i), 32'(b_if.rsp_rdata), 32'(v.brd));
        chk($sformatf("v%0d b_rsp_err", i),   32'(b_if.rsp_err),   32'(v.bre));
        chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt),  32'(v.cnt));
        chk($sformatf("v%0d ram_rst", i),     32'(ram_rst),        32'd0);
    endtask

    initial begin
        // av awe aaddr awd | bv bwe baddr bwd | ar br | wa ada dta | wb adb dtb | arv ard are | brv brd bre | cnt
        vecs[0]  = '{1'b1,1'b1,8'd5,8'h3C,  1'b0,1'b0,8'd0,8'h00,  1'b1,1'b1, 1'b1,8'd5,8'h3C, 1'b0,8'd0,8'h00,
                     1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 16'd0};
        vecs[1]  = '{1'b1,1'b0,8'd5,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b1,1'b1, 1'b0,8'd5,8'h00, 1'b0,8'd0,8'h00,
                     1'b1,8'h00,1'b0, 1'b0,8'h00,1'b0, 16'd0};
        vecs[2]  = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b1,1'b1, 1'b0,8'd0,8'h00, 1'b0,8'd0,8'h00,
                     1'b1,8'h3C,1'b0, 1'b0,8'h00,1'b0, 16'd0};
        vecs[3]  = '{1'b1,1'b1,8'd7,8'h11,  1'b1,1'b1,8'd7,8'h22,  1'b1,1'b0, 1'b1,8'd7,8'h11, 1'b0,8'd0,8'h00,
                     1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 16'd0};
        vecs[4]  = '{1'b1,1'b1,8'd7,8'h11,  1'b1,1'b1,8'd7,8'h22,  1'b0,1'b1, 1'b0,8'd0,8'h00, 1'b1,8'd7,8'h22,
                     1'b1,8'h00,1'b0, 1'b0,8'h00,1'b0, 16'd1};
        vecs[5]  = '{1'b1,1'b0,8'd7,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b1,1'b1, 1'b0,8'd7,8'h00, 1'b0,8'd0,8'h00,
                     1'b0,8'h00,1'b0, 1'b1,8'h00,1'b0, 16'd2};
        vecs[6]  = '{1'b1,1'b0,8'd3,8'h00,  1'b1,1'b0,8'd3,8'h00,  1'b1,1'b1, 1'b0,8'd3,8'h00, 1'b0,8'd3,8'h00,
                     1'b1,8'h22,1'b0, 1'b0,8'h00,1'b0, 16'd2};
        vecs[7]  = '{1'b0,1'b0,8'd0,8'h00,  1'b1,1'b0,8'd25,8'h00, 1'b1,1'b1, 1'b0,8'd0,8'h00, 1'b0,8'd0,8'h00,
                     1'b1,8'h43,1'b0, 1'b1,8'h43,1'b0, 16'd2};
        vecs[8]  = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b1,1'b1, 1'b0,8'd0,8'h00, 1'b0,8'd0,8'h00,
                     1'b0,8'h00,1'b0, 1'b1,8'h00,1'b1, 16'd2};
        vecs[9]  = '{1'b1,1'b1,8'd9,8'h5A,  1'b1,1'b0,8'd10,8'h00, 1'b1,1'b1, 1'b1,8'd9,8'h5A, 1'b0,8'd10,8'h00,
                     1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 16'd2};
        vecs[10] = '{1'b1,1'b0,8'd30,8'h00, 1'b1,1'b1,8'd30,8'h66, 1'b1,1'b1, 1'b0,8'd0,8'h00, 1'b0,8'd0,8'h00,
                     1'b1,8'h00,1'b0, 1'b1,8'h4A,1'b0, 16'd2};
        vecs[11] = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b1,1'b1, 1'b0,8'd0,8'h00, 1'b0,8'd0,8'h00,
                     1'b1,8'h00,1'b1, 1'b1,8'h00,1'b1, 16'd2};

        // reset with both clients already requesting reads of 1 and 2
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 8'd2, 8'h00);
        @(negedge clk);
        #1;
        chk("rst ram_rst",      32'(ram_rst),       32'd1);
        chk("rst a_ready",      32'(a_if.req_ready), 32'd0);
        chk("rst b_ready",      32'(b_if.req_ready), 32'd0);
        chk("rst ram_we_a",     32'(ram_we_a),      32'd0);
        chk("rst a_rsp_valid",  32'(a_if.rsp_valid), 32'd0);
        chk("rst conflict_cnt", 32'(conflict_cnt),  32'd0);
        chk("rst state",        32'(state_dbg),     32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("init%0d ram_rst", c), 32'(ram_rst),        32'd1);
            chk($sformatf("init%0d a_ready", c), 32'(a_if.req_ready), 32'd0);
            chk($sformatf("init%0d b_ready", c), 32'(b_if.req_ready), 32'd0);
            chk($sformatf("init%0d state", c),   32'(state_dbg),      32'd0);
            @(negedge clk);
        end
        #1;
        chk("run ram_rst",   32'(ram_rst),        32'd0);
        chk("run a_ready",   32'(a_if.req_ready), 32'd1);
        chk("run b_ready",   32'(b_if.req_ready), 32'd1);
        chk("run state",     32'(state_dbg),      32'd1);
        chk("run ram_add_a", 32'(ram_add_a),      32'd1);
        chk("run ram_add_b", 32'(ram_add_b),      32'd2);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);
        #1;
        chk("first a_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
        chk("first a_rsp_rdata", 32'(a_if.rsp_rdata), 32'h41);
        chk("first b_rsp_valid", 32'(b_if.rsp_valid), 32'd1);
        chk("first b_rsp_rdata", 32'(b_if.rsp_rdata), 32'h42);

        // per-cycle vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].awe, vecs[i].aaddr, vecs[i].awd,
                  vecs[i].bv, vecs[i].bwe, vecs[i].baddr, vecs[i].bwd);
            #1;
            check_vec(i);
        end

        // reset asserted just after a conflicting write pair is accepted
        @(negedge clk);
        drive(1'b1, 1'b1, 8'd5, 8'h77, 1'b1, 1'b1, 8'd5, 8'h88);
        #1;
        chk("mid a_ready", 32'(a_if.req_ready), 32'd1);
        chk("mid b_ready", 32'(b_if.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid pre a_rsp_valid",  32'(a_if.rsp_valid), 32'd1);
        chk("mid pre conflict_cnt", 32'(conflict_cnt),   32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid a_rsp_valid",  32'(a_if.rsp_valid), 32'd0);
        chk("mid b_rsp_valid",  32'(b_if.rsp_valid), 32'd0);
        chk("mid conflict_cnt", 32'(conflict_cnt),   32'd0);
        chk("mid state",        32'(state_dbg),      32'd0);
        chk("mid ram_rst",      32'(ram_rst),        32'd1);
        chk("mid a_ready",      32'(a_if.req_ready), 32'd0);
        chk("mid ram_we_a",     32'(ram_we_a),       32'd0);
        chk("mid ram_we_b",     32'(ram_we_b),       32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rel%0d a_rsp_valid", c), 32'(a_if.rsp_valid), 32'd0);
            chk($sformatf("rel%0d b_rsp_valid", c), 32'(b_if.rsp_valid), 32'd0);
            chk($sformatf("rel%0d state", c),       32'(state_dbg),      (c == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_req_arbiter.md
DPRAM_REQ_ARBITER -- requirements
Module: dpram_req_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, RAM data width.
REQ-002 SHALL have parameter AW, default 8, RAM address width.
REQ-003 SHALL have parameter DEPTH, default 20, number of valid RAM words.
REQ-004 SHALL have parameter INIT_CYCLES, default 2, cycles ram_rst is held after reset release.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have, per client X in {a,b}: x_req_valid in 1; x_req_ready out 1; x_req_we in 1; x_req_addr in AW; x_req_wdata in DW.
REQ-008 SHALL have, per client X: x_rsp_valid out 1; x_rsp_rdata out DW; x_rsp_err out 1 (no backpressure on responses).
REQ-009 SHALL have RAM-side ports: ram_rst out 1; ram_we_a, ram_we_b out 1; ram_add_a, ram_add_b out AW; ram_data_a, ram_data_b out DW; ram_read_a, ram_read_b in DW.
REQ-010 SHALL have port conflict_cnt  out  16  saturating count of address conflicts.

Function
REQ-011 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-012 In INIT: ram_rst=1, both x_req_ready=0, for exactly INIT_CYCLES cycles, then RUN.
REQ-013 In RUN: ram_rst=0; a request is accepted on a cycle where x_req_valid && x_req_ready.
REQ-014 Accepted in-range request (addr < DEPTH) SHALL drive ram_we_x=x_req_we, ram_add_x=addr, ram_data_x=wdata combinationally the same cycle.
REQ-015 Idle port SHALL drive ram_we_x=0, ram_add_x=0, ram_data_x=0.
REQ-016 Every accepted request SHALL produce x_rsp_valid=1 for exactly one cycle, the cycle after acceptance (latency 1).
REQ-017 Read response: x_rsp_rdata=ram_read_x, x_rsp_err=0; write response: x_rsp_rdata=0, x_rsp_err=0.
REQ-018 Out-of-range addr (>= DEPTH): accepted, ram_we_x=0, ram_add_x=0, response next cycle with x_rsp_err=1, x_rsp_rdata=0.
REQ-019 Conflict = both valid, both in range, addresses equal, at least one we=1.
REQ-020 On conflict SHALL grant the port indicated by priority bit prio (0=A, 1=B); loser x_req_ready=0 that cycle.
REQ-021 prio SHALL toggle after each conflict cycle, so a persistent conflict alternates winners (no starvation).
REQ-022 Non-conflict (different addresses, or read-read same address) SHALL grant both ports the same cycle.
REQ-023 x_req_ready SHALL not depend on x_req_ready of the other port; it depends only on state, valids, addrs, we, prio.
REQ-024 conflict_cnt SHALL increment by 1 per conflict cycle, saturate at 16'hFFFF.
REQ-025 Loser request SHALL remain valid and stable (client obligation); arbiter SHALL not latch it.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=INIT, INIT counter=0, prio=0, conflict_cnt=0, x_rsp_valid=0, x_rsp_err=0, x_rsp_rdata=0, pending-response flags=0.
REQ-027 During rst_n low: ram_rst=1, x_req_ready=0, all ram_we_x=0.
REQ-028 Reset mid-transaction SHALL drop any pending response; no x_rsp_valid after release until a new acceptance.

Structure
REQ-029 Shared package SHALL hold DW, AW, DEPTH defaults, INIT_CYCLES, and the state enum {INIT, RUN}.
REQ-030 SHALL instantiate one sub-module dpram_rsp_track per port (pending flag, we/err capture, response generation).

Verification
REQ-031 Reset release -> ram_rst=1 and readys=0 for 2 cycles, then readys=1 with valids high.
REQ-032 A write addr 5 data 8'h3C, next cycle A read addr 5 -> a_rsp_valid cycle after read with rdata 8'h3C, err=0.
REQ-033 A and B both write addr 7 (A 8'h11, B 8'h22), held 2 cycles -> A granted first, B second, conflict_cnt=1 then 2, final read 7 returns 8'h22.
REQ-034 A read addr 3, B read addr 3 same cycle -> both granted, no conflict_cnt change, both rsp next cycle.
REQ-035 B read addr 25 -> ram_we_b=0, b_rsp_valid next cycle with err=1, rdata=0.
REQ-036 rst_n pulled low the cycle after acceptance -> no x_rsp_valid, conflict_cnt=0, INIT re-entered.
